// File: rtl/cu_pkg.sv
// ============================================================================
//  Module   : cu_pkg
//  Purpose  : Shared types and constants for the accumulator-CPU control unit.
//             The MW state exists only when CU_MPY_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cu_pkg;

    localparam int unsigned CTRL_W = 16;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_F3   = 4'd3,
        S_DEC  = 4'd4,
        S_E1   = 4'd5,
        S_E2   = 4'd6,
        S_E3   = 4'd7,
        S_E4   = 4'd8,
`ifdef CU_MPY_EN
        S_MW   = 4'd9,
`endif
        S_EJ   = 4'd10,
        S_HALT = 4'd11
    } cu_state_e;

    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_STORE  = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_MPY    = 8'h08;

    localparam int unsigned C0  = 0;   // PC -> MAR
    localparam int unsigned C1  = 1;   // PC + 1
    localparam int unsigned C2  = 2;   // mem -> MBR
    localparam int unsigned C3  = 3;   // IR[7:0] -> MAR
    localparam int unsigned C4  = 4;   // MBR -> IR
    localparam int unsigned C5  = 5;   // MBR -> BR
    localparam int unsigned C6  = 6;   // ACC -> MBR
    localparam int unsigned C7  = 7;   // MBR -> mem
    localparam int unsigned C8  = 8;   // ACC += BR
    localparam int unsigned C9  = 9;   // ACC -= BR
    localparam int unsigned C10 = 10;  // ACC <- BR
    localparam int unsigned C11 = 11;  // IR[7:0] -> PC
    localparam int unsigned C12 = 12;  // multiplier start
    localparam int unsigned C13 = 13;  // ACC <- product
    localparam int unsigned C14 = 14;  // reserved
    localparam int unsigned C15 = 15;  // reserved

    typedef struct packed {
        logic mem_read;
        logic store;
        logic jump;
        logic jump_cond;
        logic halt;
        logic mpy;
        logic illegal;
    } cu_class_t;

    function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
        logic [CTRL_W-1:0] v;
        v            = '0;
        v[idx[3:0]]  = 1'b1;
        return v;
    endfunction

    localparam logic [CTRL_W-1:0] CTRL_RSVD_MASK = cbit(C14) | cbit(C15);

endpackage

`default_nettype wire

// File: rtl/cu_decode.sv
// ============================================================================
//  Module   : cu_decode
//  Purpose  : Maps an opcode to its execution class. Opcode 08 is legal only
//             when CU_MPY_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cu_decode
    import cu_pkg::*;
(
    input  logic [7:0] i_opcode,
    output cu_class_t  o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_LOAD,
            OP_ADD,
            OP_SUB:    o_class.mem_read = 1'b1;
            OP_STORE:  o_class.store    = 1'b1;
            OP_JMP:    o_class.jump     = 1'b1;
            OP_JMPGEZ: begin
                o_class.jump      = 1'b1;
                o_class.jump_cond = 1'b1;
            end
            OP_HALT:   o_class.halt     = 1'b1;
`ifdef CU_MPY_EN
            OP_MPY: begin
                o_class.mem_read = 1'b1;
                o_class.mpy      = 1'b1;
            end
`endif
            default:   o_class.illegal  = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
//  Module   : control_unit
//  Purpose  : Hardwired fetch/decode/execute sequencer for the 16-bit
//             accumulator CPU. Optional multiplier support via CU_MPY_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] ir_in,
    input  logic        acc_sign,
    input  logic        mem_ack,
    input  logic        alu_done,
    output logic [15:0] ctrl,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal
);

    cu_state_e          state_q, state_d;
    logic [7:0]         opcode_q, opcode_d;
    logic               illegal_q, illegal_d;

    logic [7:0]         w_dec_opcode;
    cu_class_t          w_class;
    logic [CTRL_W-1:0]  w_ctrl;

    // DEC classifies the live IR; every later state uses the latched opcode.
    assign w_dec_opcode = (state_q == S_DEC) ? ir_in[15:8] : opcode_q;

    cu_decode u_decode (
        .i_opcode (w_dec_opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        illegal_d  = illegal_q;
        w_ctrl     = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_F1;
            end
            S_F1: begin
                w_ctrl  = cbit(C0);
                state_d = S_F2;
            end
            S_F2: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    w_ctrl  = cbit(C1) | cbit(C2);
                    state_d = S_F3;
                end
            end
            S_F3: begin
                w_ctrl  = cbit(C4);
                state_d = S_DEC;
            end
            S_DEC: begin
                opcode_d = ir_in[15:8];
                if (w_class.illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (w_class.halt) begin
                    state_d = S_HALT;
                end else if (w_class.jump) begin
                    state_d = S_EJ;
                end else if (w_class.mem_read || w_class.store) begin
                    state_d = S_E1;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_E1: begin
                w_ctrl = cbit(C3);
                if (w_class.store) w_ctrl = w_ctrl | cbit(C6);
                state_d = S_E2;
            end
            S_E2: begin
                if (w_class.store) begin
                    mem_wr = 1'b1;
                    if (mem_ack) begin
                        w_ctrl     = cbit(C7);
                        instr_done = 1'b1;
                        state_d    = S_F1;
                    end
                end else begin
                    mem_rd = 1'b1;
                    if (mem_ack) begin
                        w_ctrl  = cbit(C2);
                        state_d = S_E3;
                    end
                end
            end
            S_E3: begin
                w_ctrl  = cbit(C5);
                state_d = S_E4;
            end
            S_E4: begin
                instr_done = 1'b1;
                state_d    = S_F1;
                case (opcode_q)
                    OP_LOAD: w_ctrl = cbit(C10);
                    OP_ADD:  w_ctrl = cbit(C8);
                    OP_SUB:  w_ctrl = cbit(C9);
                    default: ;
                endcase
`ifdef CU_MPY_EN
                if (w_class.mpy) begin
                    w_ctrl     = cbit(C12);
                    instr_done = 1'b0;
                    state_d    = S_MW;
                end
`endif
            end
`ifdef CU_MPY_EN
            S_MW: begin
                if (alu_done) begin
                    w_ctrl     = cbit(C13);
                    instr_done = 1'b1;
                    state_d    = S_F1;
                end
            end
`endif
            S_EJ: begin
                if (!w_class.jump_cond || !acc_sign) w_ctrl = cbit(C11);
                instr_done = 1'b1;
                state_d    = S_F1;
            end
            S_HALT: begin
                halted = 1'b1;
                if (run) state_d = S_F1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ctrl    = w_ctrl & ~CTRL_RSVD_MASK;
    assign illegal = illegal_q;

    // The operand address bypasses the sequencer and goes straight to the datapath.
    logic unused_ir_addr;
    assign unused_ir_addr = ^ir_in[7:0];

`ifndef CU_MPY_EN
    logic unused_mpy_path;
    assign unused_mpy_path = alu_done ^ w_class.mpy;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Randomized scoreboard bench for control_unit; honours CU_MPY_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n, run, acc_sign, mem_ack, alu_done;
    logic [15:0] ir_in, ctrl;
    logic        mem_rd, mem_wr, instr_done, halted, illegal;

    always #5 clk = ~clk;

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ir_in      (ir_in),
        .acc_sign   (acc_sign),
        .mem_ack    (mem_ack),
        .alu_done   (alu_done),
        .ctrl       (ctrl),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .instr_done (instr_done),
        .halted     (halted),
        .illegal    (illegal)
    );

`ifdef CU_MPY_EN
    localparam bit MPY_EN = 1'b1;
`else
    localparam bit MPY_EN = 1'b0;
`endif

    typedef logic [20:0] obs_t;   // {illegal, halted, instr_done, mem_wr, mem_rd, ctrl}
    typedef logic [19:0] stim_t;  // {run, ir_in, acc_sign, alu_done, mem_ack}

    obs_t  exp_q[$];
    int    exp_len_q[$];
    stim_t stim_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    model_ill = 1'b0;
    int    plan_len;

    function automatic logic [15:0] cb(input int n);
        logic [15:0] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic bit rnd_run();
        return ($urandom_range(0, 7) == 0);
    endfunction

    function automatic logic rnd_or(input int v);
        return (v < 0) ? 1'($urandom_range(0, 1)) : 1'(v);
    endfunction

    // One planned cycle: expected outputs plus the inputs to apply (-1 = random).
    task automatic add(input logic [15:0] c, input bit rd, input bit wr, input bit done,
                       input bit hlt, input int ack, input int ad, input int irv,
                       input int sign, input bit rn);
        logic [15:0] irw;
        irw = (irv < 0) ? 16'($urandom) : 16'(irv);
        exp_q.push_back({model_ill, hlt, done, wr, rd, c});
        stim_q.push_back({rn, irw, rnd_or(sign), rnd_or(ad), rnd_or(ack)});
        plan_len++;
    endtask

    // Reference model: expected cycle trace of one instruction from F1 onward.
    task automatic plan_instr(input logic [7:0] op, input int fw, input int ew,
                              input int mw, input int force_sign);
        int  irv, s, h;
        bit  legal;
        plan_len = 0;
        irv   = int'({op, 8'($urandom)});
        legal = (op >= 8'h01 && op <= 8'h07) || (op == 8'h08 && MPY_EN);
        add(cb(0), 0, 0, 0, 0, -1, -1, -1, -1, rnd_run());
        for (int w = 0; w < fw; w++) add('0, 1, 0, 0, 0, 0, -1, -1, -1, rnd_run());
        add(cb(1) | cb(2), 1, 0, 0, 0, 1, -1, -1, -1, rnd_run());
        add(cb(4), 0, 0, 0, 0, -1, -1, -1, -1, rnd_run());
        add('0, 0, 0, 0, 0, -1, -1, irv, -1, rnd_run());
        if (!legal || op == 8'h07) begin
            if (!legal) model_ill = 1'b1;
            h = int'($urandom_range(1, 4));
            for (int i = 0; i < h; i++) add('0, 0, 0, 0, 1, -1, -1, -1, -1, (i == h - 1));
        end else if (op == 8'h05 || op == 8'h06) begin
            s = (force_sign < 0) ? int'($urandom_range(0, 1)) : force_sign;
            add((op == 8'h06 || s == 0) ? cb(11) : 16'h0, 0, 0, 1, 0, -1, -1, -1, s, rnd_run());
        end else begin
            add(cb(3) | ((op == 8'h02) ? cb(6) : 16'h0), 0, 0, 0, 0, -1, -1, -1, -1, rnd_run());
            for (int w = 0; w < ew; w++)
                add('0, (op != 8'h02), (op == 8'h02), 0, 0, 0, -1, -1, -1, rnd_run());
            if (op == 8'h02) begin
                add(cb(7), 0, 1, 1, 0, 1, -1, -1, -1, rnd_run());
            end else begin
                add(cb(2), 1, 0, 0, 0, 1, -1, -1, -1, rnd_run());
                add(cb(5), 0, 0, 0, 0, -1, -1, -1, -1, rnd_run());
                case (op)
                    8'h01: add(cb(10), 0, 0, 1, 0, -1, -1, -1, -1, rnd_run());
                    8'h03: add(cb(8),  0, 0, 1, 0, -1, -1, -1, -1, rnd_run());
                    8'h04: add(cb(9),  0, 0, 1, 0, -1, -1, -1, -1, rnd_run());
                    default: begin
                        add(cb(12), 0, 0, 0, 0, -1, -1, -1, -1, rnd_run());
                        for (int w = 0; w < mw; w++) add('0, 0, 0, 0, 0, -1, 0, -1, -1, rnd_run());
                        add(cb(13), 0, 0, 1, 0, -1, 1, -1, -1, rnd_run());
                    end
                endcase
            end
        end
        exp_len_q.push_back(plan_len);
    endtask

    task automatic drive_plan();
        stim_t s;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(posedge clk); #1;
            {run, ir_in, acc_sign, alu_done, mem_ack} = s;
        end
    endtask

    task automatic run_pulse();
        @(posedge clk); #1;
        run = 1'b1; mem_ack = 1'b0; alu_done = 1'b0;
    endtask

    task automatic check1(input string name, input logic [15:0] got, input logic [15:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // Monitor: gathers each instruction's cycles and scores them against the queue.
    initial begin : monitor
        obs_t act_q[$];
        obs_t e, got_w, exp_w;
        bit   in_instr;
        int   len, bad, n_instr;
        in_instr = 1'b0;
        n_instr  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_instr = 1'b0;
                act_q.delete();
            end else begin
                if (ctrl[0]) in_instr = 1'b1;
                if (in_instr) begin
                    act_q.push_back({illegal, halted, instr_done, mem_wr, mem_rd, ctrl});
                    if (instr_done || (halted && run)) begin
                        n_tests++;
                        if (exp_len_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL instr_unexpected: got end after %0d cycles, expected none", act_q.size());
                        end else begin
                            len = exp_len_q.pop_front();
                            if (act_q.size() != len) begin
                                n_fail++;
                                $display("FAIL instr%0d_len: got %0d cycles expected %0d", n_instr, act_q.size(), len);
                            end
                            bad = -1; got_w = '0; exp_w = '0;
                            for (int i = 0; i < len; i++) begin
                                e = exp_q.pop_front();
                                if (bad < 0) begin
                                    if (i >= act_q.size()) begin
                                        bad = i; got_w = 'x; exp_w = e;
                                    end else if (act_q[i] !== e) begin
                                        bad = i; got_w = act_q[i]; exp_w = e;
                                    end
                                end
                            end
                            n_tests++;
                            if (bad >= 0) begin
                                n_fail++;
                                $display("FAIL instr%0d_trace cycle %0d: got {ill,hlt,done,wr,rd,ctrl}=%h expected %h",
                                         n_instr, bad, got_w, exp_w);
                            end
                        end
                        n_instr++;
                        act_q.delete();
                        in_instr = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] op;
        int         r;
        rst_n = 1'b0; run = 1'b0; ir_in = '0; acc_sign = 1'b0;
        mem_ack = 1'b0; alu_done = 1'b0;

        repeat (2) @(negedge clk);
        check1("rst_ctrl",       ctrl,       16'h0);
        check1("rst_mem_rd",     16'(mem_rd),     16'h0);
        check1("rst_mem_wr",     16'(mem_wr),     16'h0);
        check1("rst_instr_done", 16'(instr_done), 16'h0);
        check1("rst_halted",     16'(halted),     16'h0);
        check1("rst_illegal",    16'(illegal),    16'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_pulse();
        plan_instr(8'h03, 0, 0, 0, -1);   // ADD, zero-wait
        plan_instr(8'h02, 0, 3, 0, -1);   // STORE, 3 wait cycles
        plan_instr(8'h05, 0, 0, 0, 1);    // JMPGEZ, negative ACC
        plan_instr(8'h05, 0, 0, 0, 0);    // JMPGEZ, non-negative ACC
        plan_instr(8'h06, 2, 0, 0, -1);   // JMP
        plan_instr(8'h01, 1, 2, 0, -1);   // LOAD
        plan_instr(8'h04, 0, 1, 0, -1);   // SUB
        plan_instr(8'h08, 0, 0, 4, -1);   // MPY, done on 5th MW cycle
        plan_instr(8'h3F, 0, 0, 0, -1);   // illegal
        plan_instr(8'h03, 0, 0, 0, -1);
        drive_plan();

        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 19));
            if (r < 16)       op = 8'(1 + (r % 8));
            else if (r < 18)  op = 8'($urandom_range(9, 255));
            else if (r == 18) op = 8'h00;
            else              op = 8'h07;
            plan_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 4)), -1);
            drive_plan();
        end

        // Reset while a LOAD operand read is outstanding in E2.
        @(posedge clk); #1 run = 1'b0; mem_ack = 1'b0; alu_done = 1'b0;   // F1
        @(posedge clk); #1 mem_ack = 1'b1;                                  // F2
        @(posedge clk); #1 mem_ack = 1'b0;                                  // F3
        @(posedge clk); #1 ir_in = 16'h0142;                                // DEC
        @(posedge clk); #1;                                                 // E1
        @(posedge clk); #1;                                                 // E2
        #1;
        check1("e2_mem_rd_before_reset", 16'(mem_rd), 16'h1);
        rst_n = 1'b0;
        #1;
        check1("mid_reset_ctrl",    ctrl,            16'h0);
        check1("mid_reset_mem_rd",  16'(mem_rd),     16'h0);
        check1("mid_reset_mem_wr",  16'(mem_wr),     16'h0);
        check1("mid_reset_illegal", 16'(illegal),    16'h0);
        check1("mid_reset_halted",  16'(halted),     16'h0);
        model_ill = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        run_pulse();
        plan_instr(8'h03, 1, 1, 0, -1);
        drive_plan();
        @(posedge clk); #1 run = 1'b0; mem_ack = 1'b0; alu_done = 1'b0;

        repeat (100) begin
            if (exp_len_q.size() == 0) break;
            @(negedge clk);
        end
        n_tests++;
        if (exp_len_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_instrs: got %0d unfinished expected 0", exp_len_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
